dmem_responder: RTL and testbench

Data-memory responder for the CPU's data port: accepts a word load/store request from the datapath, which drives `ALUResult` as the address and `WriteData` as the store data. It inserts a programmable number of wait states, then returns `ReadData` with a one-cycle `MemReady` strobe. It replaces the zero-wait combinational data memory so the core can be tested against slow memory through a stall handshake. Illegal accesses (misaligned or out-of-range) are flagged, not performed.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_array.sv | 30 +++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   mem_state_t : responder FSM states
//   WORD_W      : data/address word width
//   addr_ok()   : word alignment and range check of a byte address
package mem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // True when addr is word aligned and its word index falls inside depth words.
  function automatic logic addr_ok(input logic [WORD_W-1:0] addr,
                                   input int unsigned      depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < WORD_W'(depth));
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x WORD_W word storage: synchronous write, combinational read, no reset.
//   clk_i   : write clock
//   we_i    : write enable
//   addr_i  : word index shared by read and write
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WORD_W-1:0]        wdata_i,
  output logic [WORD_W-1:0]        rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU data port. Accepts a word load/store,
// waits LATENCY cycles, then commits and raises MemReady for one cycle.
// Misaligned or out-of-range accesses are flagged with MemErr, not performed.
//   clk, reset           : clock, synchronous active-high reset
//   MemReq, MemWrite     : request valid, 1 = store
//   Addr, WriteData      : byte address and store data
//   ReadData             : registered load data (store echoes written word)
//   MemReady, MemErr     : one-cycle response strobe and its error qualifier
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReq,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] Addr,
  input  logic [WORD_W-1:0] WriteData,
  output logic [WORD_W-1:0] ReadData,
  output logic              MemReady,
  output logic              MemErr
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned LAT_M1   = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam bit          ZERO_LAT = (LATENCY == 0);

  mem_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;

  logic              commit_c;
  logic              c_wr;
  logic [WORD_W-1:0] c_addr;
  logic [WORD_W-1:0] c_wdata;
  logic              c_ok;
  logic [AW-1:0]     c_idx;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  // With zero latency the commit edge is the accept edge, so the live request
  // is committed; otherwise the captured copy is.
  assign c_wr    = ZERO_LAT ? MemWrite  : wr_q;
  assign c_addr  = ZERO_LAT ? Addr      : addr_q;
  assign c_wdata = ZERO_LAT ? WriteData : wdata_q;
  assign c_ok    = addr_ok(c_addr, DEPTH);
  assign c_idx   = c_addr[AW+1:2];

  // Edge that enters RESP; reset on this edge suppresses the commit.
  assign commit_c = !reset &&
                    (((state_q == IDLE) && MemReq && ZERO_LAT) ||
                     ((state_q == BUSY) && (cnt_q == '0)));

  assign mem_we = commit_c && c_ok && c_wr;

  mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (c_idx),
    .wdata_i (c_wdata),
    .rdata_o (mem_rdata)
  );

  // FSM, wait-state counter, capture registers and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (commit_c) begin
        ready_q <= 1'b1;
        err_q   <= !c_ok;
        if (!c_ok) begin
          rdata_q <= '0;
        end else if (c_wr) begin
          rdata_q <= c_wdata;
        end else begin
          rdata_q <= mem_rdata;
        end
      end

      case (state_q)
        IDLE: begin
          if (MemReq) begin
            wr_q    <= MemWrite;
            addr_q  <= Addr;
            wdata_q <= WriteData;
            cnt_q   <= CNT_W'(LAT_M1);
            state_q <= ZERO_LAT ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign MemErr   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with LATENCY=2 and one with
// LATENCY=0, both DEPTH=64. Inputs change and outputs are sampled on negedges.
module tb_dmem_responder;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst2, req2, wr2;
  logic [31:0] addr2, wd2, rd2;
  logic        rdy2, err2;
  logic        rst0, req0, wr0;
  logic [31:0] addr0, wd0, rd0;
  logic        rdy0, err0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .reset(rst2), .MemReq(req2), .MemWrite(wr2), .Addr(addr2),
    .WriteData(wd2), .ReadData(rd2), .MemReady(rdy2), .MemErr(err2)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
    .clk(clk), .reset(rst0), .MemReq(req0), .MemWrite(wr0), .Addr(addr0),
    .WriteData(wd0), .ReadData(rd0), .MemReady(rdy0), .MemErr(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      req0 = req; wr0 = wr; addr0 = a; wd0 = d;
    end else begin
      req2 = req; wr2 = wr; addr2 = a; wd2 = d;
    end
  endtask

  function automatic logic get_rdy(input bit sel);
    return sel ? rdy0 : rdy2;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? err0 : err2;
  endfunction

  function automatic logic [31:0] get_rd(input bit sel);
    return sel ? rd0 : rd2;
  endfunction

  // One transaction from IDLE: check cycles accept->MemReady (LATENCY+1,
  // counting the accept cycle), response data/error, and single-cycle strobe.
  task automatic run_txn(input bit sel, input vec_t v, input int lat);
    int  cyc;
    bit  seen;
    @(negedge clk);
    drive(sel, 1'b1, v.wr, v.addr, v.wdata);
    @(negedge clk);                       // accept edge has passed
    drive(sel, 1'b0, 1'b0, 32'h5555_AAAA, 32'h0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (get_rdy(sel)) seen = 1'b1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    chk({v.name, " latency"}, 32'(seen ? cyc + 1 : -1), 32'(lat + 1));
    chk({v.name, " rdata"}, get_rd(sel), v.exp_rdata);
    chk({v.name, " err"}, 32'(get_err(sel)), 32'(v.exp_err));
    @(negedge clk);
    chk({v.name, " strobe one cycle"}, 32'(get_rdy(sel)), 32'd0);
  endtask

  // Watch n negedges and report whether MemReady ever rose.
  task automatic watch_quiet(input string name, input int n);
    bit any;
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rdy2) any = 1'b1;
      @(negedge clk);
    end
    chk(name, 32'(any), 32'd0);
  endtask

  vec_t v2[12];
  vec_t v0[5];

  initial begin
    v2[0]  = '{"st 10",      1'b1, 32'h10,       32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    v2[1]  = '{"ld 10",      1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    v2[2]  = '{"st 00",      1'b1, 32'h0,        32'hA5A50001, 32'hA5A50001, 1'b0};
    v2[3]  = '{"st fc last", 1'b1, 32'hFC,       32'h0BADF00D, 32'h0BADF00D, 1'b0};
    v2[4]  = '{"ld fc last", 1'b0, 32'hFC,       32'h0,        32'h0BADF00D, 1'b0};
    v2[5]  = '{"ld 13 mis",  1'b0, 32'h13,       32'h0,        32'h0,        1'b1};
    v2[6]  = '{"st 100 oor", 1'b1, 32'h100,      32'hFFFFFFFF, 32'h0,        1'b1};
    v2[7]  = '{"ld 00 kept", 1'b0, 32'h0,        32'h0,        32'hA5A50001, 1'b0};
    v2[8]  = '{"st msb oor", 1'b1, 32'h80000000, 32'h1,        32'h0,        1'b1};
    v2[9]  = '{"ld 00 kept2",1'b0, 32'h0,        32'h0,        32'hA5A50001, 1'b0};
    v2[10] = '{"st 20",      1'b1, 32'h20,       32'h11111111, 32'h11111111, 1'b0};
    v2[11] = '{"ld 02 mis",  1'b0, 32'h2,        32'h0,        32'h0,        1'b1};

    v0[0]  = '{"L0 st 00",   1'b1, 32'h0,   32'h1,        32'h1, 1'b0};
    v0[1]  = '{"L0 st 04",   1'b1, 32'h4,   32'h2,        32'h2, 1'b0};
    v0[2]  = '{"L0 ld 00",   1'b0, 32'h0,   32'h0,        32'h1, 1'b0};
    v0[3]  = '{"L0 ld 05",   1'b0, 32'h5,   32'h0,        32'h0, 1'b1};
    v0[4]  = '{"L0 st 100",  1'b1, 32'h100, 32'hDEADDEAD, 32'h0, 1'b1};

    rst2 = 1'b1; rst0 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst2 = 1'b0; rst0 = 1'b0;

    // Reset values hold until the first accept.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset rdata L2", rd2, 32'h0);
      chk("reset ready L2", 32'(rdy2), 32'd0);
      chk("reset err L2", 32'(err2), 32'd0);
      chk("reset rdata L0", rd0, 32'h0);
      chk("reset ready L0", 32'(rdy0), 32'd0);
      chk("reset err L0", 32'(err0), 32'd0);
    end

    for (int i = 0; i < 12; i++) run_txn(1'b0, v2[i], 2);
    for (int i = 0; i < 5; i++)  run_txn(1'b1, v0[i], 0);

    // LATENCY=0, MemReq held high: responses every second cycle.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b2b ready 1", 32'(rdy0), 32'd1);
    chk("b2b data 1", rd0, 32'h1);
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    chk("b2b gap", 32'(rdy0), 32'd0);
    @(negedge clk);
    chk("b2b ready 2", 32'(rdy0), 32'd1);
    chk("b2b data 2", rd0, 32'h2);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b2b end", 32'(rdy0), 32'd0);

    // LATENCY=2: request activity during BUSY/RESP must be ignored.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'hFC, 32'hCAFECAFE);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'hFC, 32'hCAFECAFE);
    @(negedge clk);
    chk("tog ready", 32'(rdy2), 32'd1);
    chk("tog rdata", rd2, 32'hDEADBEEF);
    chk("tog err", 32'(err2), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'hCAFECAFE);
    @(negedge clk);
    chk("tog strobe", 32'(rdy2), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    watch_quiet("tog no extra resp", 4);
    run_txn(1'b0, '{"tog ld fc", 1'b0, 32'hFC, 32'h0, 32'h0BADF00D, 1'b0}, 2);
    run_txn(1'b0, '{"tog ld 00", 1'b0, 32'h0,  32'h0, 32'hA5A50001, 1'b0}, 2);

    // Reset during BUSY abandons the store.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    chk("rst busy rdata", rd2, 32'h0);
    watch_quiet("rst busy no resp", 6);
    run_txn(1'b0, '{"rst busy ld 20", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0}, 2);

    // Reset on the commit edge wins.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h22222222);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    chk("rst commit rdata", rd2, 32'h0);
    watch_quiet("rst commit no resp", 6);
    run_txn(1'b0, '{"rst commit ld 20", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0}, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
